// File: rtl/node_sequencer.sv
// Replica-exchange node sequencer: staggers PHASE_NUM optimisation phases over a
// ring of BASE_NUM bases, with base-ID pipelines, a Taylor reciprocal stream, abort and drain.
module node_sequencer #(
  parameter int BASE_NUM   = 8,
  parameter int PHASE_NUM  = 2,
  parameter int STAGGER    = 4,
  parameter int CYCLE_LEN  = 20,
  parameter int PIPE_DEPTH = 5,
  parameter int EXP_TERMS  = 15,
  parameter int RECIP_FRAC = 15,
  parameter int CNT_W      = 24,
  localparam int BASE_LOG  = $clog2(BASE_NUM),
  localparam int RECIP_W   = RECIP_FRAC + 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run_write,
  input  logic [CNT_W-1:0]              run_times,
  input  logic                          abort,
  input  logic                          change_base_id,
  output logic                          running,
  output logic                          done,
  output logic [PHASE_NUM-1:0]          phase_en,
  output logic                          opt_run,
  output logic                          opt_fin,
  output logic [PHASE_NUM*BASE_LOG-1:0] rn_base_id,
  output logic [PHASE_NUM*BASE_LOG-1:0] dd_base_id,
  output logic [PHASE_NUM*BASE_LOG-1:0] ex_base_id,
  output logic                          exp_init,
  output logic                          exp_run,
  output logic                          exp_fin,
  output logic [RECIP_W-1:0]            exp_recip,
  output logic [1:0]                    state_dbg
);

  // Control contract: run_write, abort and change_base_id are single-cycle level
  // requests sampled every clock; there is no back-pressure. abort wins over
  // run_write, and run_write / change_base_id are only honoured in IDLE.

  localparam int CYC_W = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;
  localparam int K_W   = $clog2(EXP_TERMS + 1);
  localparam int ROM_N = 1 << K_W;
  localparam int DR_W  = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH - 1) : 1;
  localparam int unsigned RECIP_ONE = 32'd1 << RECIP_FRAC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CYC_W-1:0]     cyc;
  logic [DR_W-1:0]      drain_cnt;
  logic [CNT_W-1:0]     run_times_q;
  logic [BASE_LOG-1:0]  base [PHASE_NUM];
  logic [CNT_W-1:0]     sw   [PHASE_NUM];
  logic [PHASE_NUM-1:0] en_next;
  logic [PHASE_NUM-1:0] started;
  logic [BASE_LOG-1:0]  hist [PHASE_NUM][1:PIPE_DEPTH-1];
  logic [BASE_LOG-1:0]  dd_q [PHASE_NUM];
  logic [BASE_LOG-1:0]  ex_q [PHASE_NUM];
  logic [K_W-1:0]       k;
  logic [RECIP_W-1:0]   recip_rom [ROM_N];

  logic in_idle, in_run, in_drain;
  logic period_start, period_end;
  logic start_req, zero_req, change_ok, drain_end;

  function automatic logic [BASE_LOG-1:0] base_inc(input logic [BASE_LOG-1:0] b);
    return (b == BASE_LOG'(BASE_NUM - 1)) ? '0 : b + BASE_LOG'(1);
  endfunction

  // Reciprocal table 2^RECIP_FRAC / j, fixed at elaboration; entry 0 and unused tail are 0.
  for (genvar j = 0; j < ROM_N; j++) begin : g_rom
    localparam int unsigned DIV = (j == 0) ? 1 : j;
    localparam int unsigned VAL = (j == 0 || j > EXP_TERMS) ? 0 : RECIP_ONE / DIV;
    assign recip_rom[j] = RECIP_W'(VAL);
  end

  assign in_idle      = (state == S_IDLE);
  assign in_run       = (state == S_RUN);
  assign in_drain     = (state == S_DRAIN);
  assign running      = !in_idle;
  assign period_start = running && (cyc == '0);
  assign period_end   = running && (cyc == CYC_W'(CYCLE_LEN - 1));
  assign opt_run      = period_start;
  assign opt_fin      = period_end;
  assign exp_init     = period_start;
  assign exp_fin      = running && (cyc == CYC_W'(CYCLE_LEN - 2));
  assign state_dbg    = state;

  assign start_req = in_idle && run_write && !abort && (run_times != '0);
  assign zero_req  = in_idle && run_write && !abort && (run_times == '0);
  assign change_ok = in_idle && change_base_id && !abort && !start_req;
  assign drain_end = in_drain && period_end && (drain_cnt == DR_W'(PIPE_DEPTH - 2));

  // Enables as they will be after this period end: finished sweeps drop out,
  // the next phase joins once its predecessor reaches the stagger point.
  always_comb begin
    en_next = phase_en;
    for (int p = 0; p < PHASE_NUM; p++) begin
      if (phase_en[p] && base[p] == BASE_LOG'(BASE_NUM - 1) &&
          (sw[p] + CNT_W'(1)) == run_times_q)
        en_next[p] = 1'b0;
    end
    for (int p = 1; p < PHASE_NUM; p++) begin
      if (phase_en[p-1] && base[p-1] == BASE_LOG'(STAGGER - 1) && !started[p])
        en_next[p] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_req) state_next = S_RUN;
        S_RUN:   if (period_end && en_next == '0) state_next = S_DRAIN;
        S_DRAIN: if (drain_end) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc         <= '0;
      drain_cnt   <= '0;
      run_times_q <= '0;
      done        <= 1'b0;
    end else begin
      done <= !abort && (zero_req || drain_end);
      if (abort || in_idle || period_end) cyc <= '0;
      else                                cyc <= cyc + CYC_W'(1);
      if (start_req) run_times_q <= run_times;
      if (abort || !in_drain) drain_cnt <= '0;
      else if (period_end)    drain_cnt <= drain_cnt + DR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_en <= '0;
      started  <= '0;
      for (int p = 0; p < PHASE_NUM; p++) begin
        base[p] <= '0;
        sw[p]   <= '0;
      end
    end else if (abort) begin
      phase_en <= '0;
    end else if (start_req) begin
      phase_en <= PHASE_NUM'(1);
      started  <= PHASE_NUM'(1);
      for (int p = 0; p < PHASE_NUM; p++) sw[p] <= '0;
    end else if (change_ok) begin
      for (int p = 0; p < PHASE_NUM; p++) base[p] <= base_inc(base[p]);
    end else if (in_run && period_end) begin
      phase_en <= en_next;
      started  <= started | en_next;
      for (int p = 0; p < PHASE_NUM; p++) begin
        if (phase_en[p]) begin
          base[p] <= base_inc(base[p]);
          if (base[p] == BASE_LOG'(BASE_NUM - 1)) sw[p] <= sw[p] + CNT_W'(1);
        end
      end
    end
  end

  // Base-ID history feeding the distance and exchange stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PHASE_NUM; p++) begin
        for (int i = 1; i < PIPE_DEPTH; i++) hist[p][i] <= '0;
        dd_q[p] <= '0;
        ex_q[p] <= '0;
      end
    end else if (!abort) begin
      for (int p = 0; p < PHASE_NUM; p++) begin
        if (period_start) begin
          hist[p][1] <= base[p];
          for (int i = 2; i < PIPE_DEPTH; i++) hist[p][i] <= hist[p][i-1];
        end
        if (period_end) begin
          dd_q[p] <= hist[p][1];
          ex_q[p] <= hist[p][PIPE_DEPTH-1];
        end else if (in_idle) begin
          ex_q[p] <= change_ok ? base_inc(base[p]) : base[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      exp_run   <= 1'b0;
      exp_recip <= '0;
    end else if (abort) begin
      k       <= '0;
      exp_run <= 1'b0;
    end else if (period_start) begin
      exp_recip <= recip_rom[K_W'(EXP_TERMS)];
      exp_run   <= 1'b1;
      k         <= K_W'(EXP_TERMS - 1);
    end else if (k != '0) begin
      exp_recip <= recip_rom[k];
      exp_run   <= 1'b1;
      k         <= k - K_W'(1);
    end else begin
      exp_run <= 1'b0;
    end
  end

  for (genvar p = 0; p < PHASE_NUM; p++) begin : g_out
    assign rn_base_id[p*BASE_LOG +: BASE_LOG] = base[p];
    assign dd_base_id[p*BASE_LOG +: BASE_LOG] = dd_q[p];
    assign ex_base_id[p*BASE_LOG +: BASE_LOG] = ex_q[p];
  end

endmodule

// File: tb/tb_node_sequencer.sv
// Directed bench for node_sequencer at default parameters: per-feature tasks with
// inline comparisons against hand-computed values.
module tb_node_sequencer;

  logic        clk = 1'b0;
  logic        reset, run_write, abort, change_base_id;
  logic [23:0] run_times;
  logic        running, done, opt_run, opt_fin, exp_init, exp_run, exp_fin;
  logic [1:0]  phase_en, state_dbg;
  logic [5:0]  rn_base_id, dd_base_id, ex_base_id;
  logic [16:0] exp_recip;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  node_sequencer dut (
    .clk(clk), .reset(reset), .run_write(run_write), .run_times(run_times),
    .abort(abort), .change_base_id(change_base_id), .running(running), .done(done),
    .phase_en(phase_en), .opt_run(opt_run), .opt_fin(opt_fin),
    .rn_base_id(rn_base_id), .dd_base_id(dd_base_id), .ex_base_id(ex_base_id),
    .exp_init(exp_init), .exp_run(exp_run), .exp_fin(exp_fin),
    .exp_recip(exp_recip), .state_dbg(state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [23:0] rt);
    run_write = 1'b1;
    run_times = rt;
    tick();
    run_write = 1'b0;
  endtask

  // Called on the first cycle of a run; follows it until it has been idle 3 cycles.
  task automatic watch_run(output int run_cyc, output int done_cnt, output int fins,
                           output int rise1, output int fall0, output int fall1,
                           output bit timeout);
    logic [1:0] prev_en;
    int idle_seen;
    run_cyc = 0; done_cnt = 0; fins = 0; rise1 = -1; fall0 = -1; fall1 = -1;
    timeout = 1'b1; idle_seen = 0; prev_en = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      if (running) run_cyc++;
      if (done) done_cnt++;
      if (!prev_en[1] && phase_en[1]) rise1 = fins;
      if (prev_en[0] && !phase_en[0]) fall0 = fins;
      if (prev_en[1] && !phase_en[1]) fall1 = fins;
      prev_en = phase_en;
      if (opt_fin) fins++;
      if (!running) idle_seen++;
      if (idle_seen == 3) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run_write = 1'b0; run_times = '0; abort = 1'b0; change_base_id = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({running, done, opt_run, exp_run} !== 4'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000", {running, done, opt_run, exp_run});
    end
    tests_run++;
    if (phase_en !== 2'b00) begin fails++; $display("FAIL reset_phase_en: got %b want 00", phase_en); end
    tests_run++;
    if ({rn_base_id, dd_base_id, ex_base_id} !== 18'd0) begin
      fails++; $display("FAIL reset_bases: got %h want 0", {rn_base_id, dd_base_id, ex_base_id});
    end
    tests_run++;
    if (exp_recip !== 17'd0) begin fails++; $display("FAIL reset_recip: got %0d want 0", exp_recip); end
    tests_run++;
    if (state_dbg !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_zero_run();
    run_write = 1'b1; run_times = 24'd0;
    tick();
    run_write = 1'b0;
    tests_run++;
    if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", done); end
    tests_run++;
    if (running !== 1'b0) begin fails++; $display("FAIL zero_running: got %b want 0", running); end
    tick();
    tests_run++;
    if ({done, running} !== 2'b00) begin fails++; $display("FAIL zero_after: got %b want 00", {done, running}); end
  endtask

  task automatic test_single_run();
    int rc, dc, fn, r1, f0, f1;
    bit to;
    start_run(24'd1);
    tests_run++;
    if ({running, opt_run, phase_en} !== 4'b1101) begin
      fails++; $display("FAIL run1_start: got %b want 1101", {running, opt_run, phase_en});
    end
    watch_run(rc, dc, fn, r1, f0, f1, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL run1_timeout: got 1 want 0"); end
    tests_run++;
    if (rc != 320) begin fails++; $display("FAIL run1_length: got %0d want 320", rc); end
    tests_run++;
    if (dc != 1) begin fails++; $display("FAIL run1_done: got %0d want 1", dc); end
    tests_run++;
    if (r1 != 4) begin fails++; $display("FAIL run1_en1_rise: got %0d want 4", r1); end
    tests_run++;
    if (f0 != 8) begin fails++; $display("FAIL run1_en0_fall: got %0d want 8", f0); end
    tests_run++;
    if (f1 != 12) begin fails++; $display("FAIL run1_en1_fall: got %0d want 12", f1); end
    tests_run++;
    if (fn != 16) begin fails++; $display("FAIL run1_fins: got %0d want 16", fn); end
    tests_run++;
    if (rn_base_id !== 6'd0) begin fails++; $display("FAIL run1_bases: got %h want 0", rn_base_id); end
  endtask

  task automatic test_exp_stream();
    logic [16:0] exp_tab [15];
    int dc;
    exp_tab = '{17'd2184, 17'd2340, 17'd2520, 17'd2730, 17'd2978, 17'd3276, 17'd3640,
                17'd4096, 17'd4681, 17'd5461, 17'd6553, 17'd8192, 17'd10922, 17'd16384, 17'd32768};
    start_run(24'd1);
    tests_run++;
    if ({exp_init, exp_run} !== 2'b10) begin fails++; $display("FAIL exp_init: got %b want 10", {exp_init, exp_run}); end
    for (int j = 0; j < 15; j++) begin
      tick();
      tests_run++;
      if (exp_run !== 1'b1 || exp_recip !== exp_tab[j]) begin
        fails++; $display("FAIL exp_term%0d: got run=%b recip=%0d want run=1 recip=%0d", j, exp_run, exp_recip, exp_tab[j]);
      end
    end
    tick();
    tests_run++;
    if (exp_run !== 1'b0 || exp_recip !== 17'd32768) begin
      fails++; $display("FAIL exp_end: got run=%b recip=%0d want run=0 recip=32768", exp_run, exp_recip);
    end
    tick(); tick();
    tests_run++;
    if ({exp_fin, opt_fin} !== 2'b10) begin fails++; $display("FAIL exp_fin: got %b want 10", {exp_fin, opt_fin}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dc++;
      tick();
    end
    tests_run++;
    if (running !== 1'b0 || dc != 0) begin fails++; $display("FAIL exp_abort: got running=%b done=%0d want 0 0", running, dc); end
  endtask

  task automatic test_pipeline();
    bit to;
    start_run(24'd1);
    repeat (100) tick();
    tests_run++;
    if (ex_base_id[2:0] !== 3'd1) begin fails++; $display("FAIL pipe_ex0: got %0d want 1", ex_base_id[2:0]); end
    tests_run++;
    if (dd_base_id[2:0] !== 3'd4) begin fails++; $display("FAIL pipe_dd0: got %0d want 4", dd_base_id[2:0]); end
    tests_run++;
    if (dd_base_id[5:3] !== 3'd0) begin fails++; $display("FAIL pipe_dd1: got %0d want 0", dd_base_id[5:3]); end
    tests_run++;
    if (rn_base_id !== {3'd1, 3'd5}) begin fails++; $display("FAIL pipe_rn: got %h want %h", rn_base_id, {3'd1, 3'd5}); end
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!running) begin to = 1'b0; break; end
      tick();
    end
    tick(); tick();
    tests_run++;
    if (to) begin fails++; $display("FAIL pipe_timeout: got 1 want 0"); end
    tests_run++;
    if (ex_base_id !== 6'd0) begin fails++; $display("FAIL pipe_ex_idle: got %h want 0", ex_base_id); end
  endtask

  task automatic test_double_run();
    int rc, dc, fn, r1, f0, f1;
    bit to;
    start_run(24'd2);
    watch_run(rc, dc, fn, r1, f0, f1, to);
    tests_run++;
    if (to || rc != 480) begin fails++; $display("FAIL run2_length: got %0d (timeout %b) want 480", rc, to); end
    tests_run++;
    if (dc != 1) begin fails++; $display("FAIL run2_done: got %0d want 1", dc); end
    tests_run++;
    if (r1 != 4 || f0 != 16 || f1 != 20) begin
      fails++; $display("FAIL run2_enables: got %0d/%0d/%0d want 4/16/20", r1, f0, f1);
    end
    tests_run++;
    if (rn_base_id !== 6'd0) begin fails++; $display("FAIL run2_bases: got %h want 0", rn_base_id); end
  endtask

  task automatic test_rewrite_ignored();
    int n, dn;
    start_run(24'd1);
    n = 0; dn = 0;
    for (int i = 0; i < 330; i++) begin
      if (running) n++;
      if (done) dn++;
      run_write = (i == 50);
      run_times = 24'd5;
      tick();
    end
    run_write = 1'b0;
    tests_run++;
    if (n != 320) begin fails++; $display("FAIL rewrite_length: got %0d want 320", n); end
    tests_run++;
    if (dn != 1) begin fails++; $display("FAIL rewrite_done: got %0d want 1", dn); end
  endtask

  task automatic test_abort();
    int rc, dc, fn, r1, f0, f1, d;
    bit to;
    start_run(24'd1);
    repeat (45) tick();
    tests_run++;
    if (exp_run !== 1'b1) begin fails++; $display("FAIL abort_pre_exp: got %b want 1", exp_run); end
    abort = 1'b1;
    run_write = 1'b1;
    run_times = 24'd1;
    tick();
    abort = 1'b0;
    run_write = 1'b0;
    tests_run++;
    if ({running, phase_en, exp_run, opt_run} !== 5'b0) begin
      fails++; $display("FAIL abort_clear: got %b want 00000", {running, phase_en, exp_run, opt_run});
    end
    tests_run++;
    if (rn_base_id !== {3'd0, 3'd2}) begin fails++; $display("FAIL abort_bases: got %h want %h", rn_base_id, {3'd0, 3'd2}); end
    d = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || running) d++;
      tick();
    end
    tests_run++;
    if (d != 0) begin fails++; $display("FAIL abort_no_done: got %0d want 0", d); end
    start_run(24'd1);
    watch_run(rc, dc, fn, r1, f0, f1, to);
    tests_run++;
    if (to || rc != 280 || dc != 1) begin
      fails++; $display("FAIL abort_restart: got len=%0d done=%0d timeout=%b want 280 1 0", rc, dc, to);
    end
    tests_run++;
    if (r1 != 2 || f0 != 6 || f1 != 10) begin
      fails++; $display("FAIL abort_restart_en: got %0d/%0d/%0d want 2/6/10", r1, f0, f1);
    end
    tests_run++;
    if (rn_base_id !== 6'd0) begin fails++; $display("FAIL abort_restart_bases: got %h want 0", rn_base_id); end
  endtask

  task automatic test_change_base();
    change_base_id = 1'b1;
    tick();
    change_base_id = 1'b0;
    tests_run++;
    if (ex_base_id !== {3'd1, 3'd1}) begin fails++; $display("FAIL change_ex: got %h want %h", ex_base_id, {3'd1, 3'd1}); end
    tests_run++;
    if (rn_base_id !== {3'd1, 3'd1}) begin fails++; $display("FAIL change_rn: got %h want %h", rn_base_id, {3'd1, 3'd1}); end
    tick();
    tests_run++;
    if (ex_base_id !== {3'd1, 3'd1}) begin fails++; $display("FAIL change_hold: got %h want %h", ex_base_id, {3'd1, 3'd1}); end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_single_run();
    test_exp_stream();
    test_pipeline();
    test_double_run();
    test_rewrite_ignored();
    test_abort();
    test_change_base();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
